// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared sizing constants and types for the 8-deep byte FIFO controller.
//   ADDR_WIDTH : byte-slot address width
//   DEPTH      : number of byte slots (2**ADDR_WIDTH)
//   WR_STRIDE  : byte slots consumed by one 16-bit write (fixed at 2)
//   addr_t     : byte-slot pointer type
//   cnt_t      : occupancy type, one bit wider than a pointer (0..DEPTH)
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int ADDR_WIDTH = 3;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int WR_STRIDE  = 2;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [ADDR_WIDTH:0]   cnt_t;

endpackage

// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
// Pointer and occupancy controller for the byte FIFO register file. Each
// accepted write fills two consecutive byte slots; each accepted read drains
// one byte slot.
// Ports:
//   clk     in  : system clock, rising edge
//   reset   in  : synchronous active-high reset
//   wr      in  : write request (one 16-bit word)
//   rd      in  : read request (one byte)
//   err_clr in  : clears sticky ovf/udf
//   w_en    out : register file write enable (wr & ~full)
//   w_addr  out : write pointer, low byte slot of the word
//   r_addr  out : read pointer
//   full    out : fewer than WR_STRIDE free slots
//   empty   out : no bytes stored
//   count   out : bytes stored, 0..DEPTH
//   ovf     out : sticky, write requested while full
//   udf     out : sticky, read requested while empty
// -----------------------------------------------------------------------------
module fifo_ctrl
    import fifo_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  wr,
    input  logic  rd,
    input  logic  err_clr,
    output logic  w_en,
    output addr_t w_addr,
    output addr_t r_addr,
    output logic  full,
    output logic  empty,
    output cnt_t  count,
    output logic  ovf,
    output logic  udf
);

    // Signed, one bit wider than cnt_t so the +2/-1 arithmetic never wraps.
    typedef logic signed [ADDR_WIDTH+1:0] cnt_ext_t;

    localparam cnt_t FULL_THRESH = cnt_t'(DEPTH - WR_STRIDE);

    addr_t    w_ptr_r;
    addr_t    r_ptr_r;
    cnt_t     cnt_r;
    logic     ovf_r;
    logic     udf_r;

    logic     wa_s;
    logic     ra_s;
    cnt_ext_t cnt_ext_s;
    cnt_t     cnt_next_s;
    logic     ovf_next_s;
    logic     udf_next_s;

    // Status flags and accept terms, all judged on pre-edge occupancy.
    always_comb begin
        empty = (cnt_r == cnt_t'(0));
        full  = (cnt_r > FULL_THRESH);
        wa_s  = wr & ~full;
        ra_s  = rd & ~empty;
    end

    // Occupancy update; a simultaneous accepted write and read nets +1.
    always_comb begin
        cnt_ext_s  = cnt_ext_t'(cnt_r)
                   + (wa_s ? cnt_ext_t'(WR_STRIDE) : cnt_ext_t'(0))
                   - (ra_s ? cnt_ext_t'(1)         : cnt_ext_t'(0));
        cnt_next_s = cnt_t'(cnt_ext_s);
    end

    // Sticky error flags: a new error event beats a same-cycle clear.
    always_comb begin
        if (wr & full) begin
            ovf_next_s = 1'b1;
        end else if (err_clr) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end

        if (rd & empty) begin
            udf_next_s = 1'b1;
        end else if (err_clr) begin
            udf_next_s = 1'b0;
        end else begin
            udf_next_s = udf_r;
        end
    end

    // State register: pointers wrap modulo DEPTH by natural truncation.
    // w_ptr only ever moves in steps of two, so it stays even and the upper
    // byte of a word (w_ptr+1) never straddles the wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr_r <= addr_t'(0);
            r_ptr_r <= addr_t'(0);
            cnt_r   <= cnt_t'(0);
            ovf_r   <= 1'b0;
            udf_r   <= 1'b0;
        end else begin
            if (wa_s) begin
                w_ptr_r <= w_ptr_r + addr_t'(WR_STRIDE);
            end
            if (ra_s) begin
                r_ptr_r <= r_ptr_r + addr_t'(1);
            end
            cnt_r <= cnt_next_s;
            ovf_r <= ovf_next_s;
            udf_r <= udf_next_s;
        end
    end

    // Output mapping; w_en stays combinational so the register file writes
    // on the same edge that advances the write pointer.
    always_comb begin
        w_en   = wa_s;
        w_addr = w_ptr_r;
        r_addr = r_ptr_r;
        count  = cnt_r;
        ovf    = ovf_r;
        udf    = udf_r;
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl
// Pairs fifo_ctrl with a behavioural byte register file. A driver issues one
// request set per cycle and pushes the expected response, computed from a
// byte-queue reference model, into a scoreboard queue; a monitor on the
// falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl;

    localparam int DEPTH  = 8;
    localparam int STRIDE = 2;

    logic       clk;
    logic       reset;
    logic       wr;
    logic       rd;
    logic       err_clr;
    logic       w_en;
    logic [2:0] w_addr;
    logic [2:0] r_addr;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       ovf;
    logic       udf;

    logic [15:0] wdata;
    logic [7:0]  mem [0:DEPTH-1];

    typedef struct {
        logic       w_en;
        logic [2:0] w_addr;
        logic [2:0] r_addr;
        logic       full;
        logic       empty;
        logic [3:0] count;
        logic       ovf;
        logic       udf;
        logic       rd_ok;
        logic [7:0] rbyte;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] model_q [$];
    int         wr_acc;
    int         rd_acc;
    logic       ovf_m;
    logic       udf_m;

    int checks;
    int errors;

    fifo_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr),
        .rd      (rd),
        .err_clr (err_clr),
        .w_en    (w_en),
        .w_addr  (w_addr),
        .r_addr  (r_addr),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .ovf     (ovf),
        .udf     (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: two byte slots written per accepted word.
    always @(posedge clk) begin
        if (w_en) begin
            mem[w_addr]        <= wdata[7:0];
            mem[w_addr + 3'd1] <= wdata[15:8];
        end
    end

    function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compares every presented cycle against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("w_en",   16'(w_en),   16'(e.w_en));
            chk("w_addr", 16'(w_addr), 16'(e.w_addr));
            chk("r_addr", 16'(r_addr), 16'(e.r_addr));
            chk("full",   16'(full),   16'(e.full));
            chk("empty",  16'(empty),  16'(e.empty));
            chk("count",  16'(count),  16'(e.count));
            chk("ovf",    16'(ovf),    16'(e.ovf));
            chk("udf",    16'(udf),    16'(e.udf));
            if (e.rd_ok) begin
                chk("r_data", 16'(mem[r_addr]), 16'(e.rbyte));
            end
        end
    end

    // One cycle of stimulus: predict outputs from pre-edge model, then step it.
    task automatic cycle(input logic rs, input logic w, input logic r, input logic c);
        exp_t e;
        logic m_full;
        logic m_empty;
        @(posedge clk);
        #1;
        reset   = rs;
        wr      = w;
        rd      = r;
        err_clr = c;
        wdata   = 16'($urandom());

        m_full   = (model_q.size() > DEPTH - STRIDE);
        m_empty  = (model_q.size() == 0);
        e.w_en   = w & ~m_full;
        e.w_addr = 3'((STRIDE * wr_acc) % DEPTH);
        e.r_addr = 3'(rd_acc % DEPTH);
        e.full   = m_full;
        e.empty  = m_empty;
        e.count  = 4'(model_q.size());
        e.ovf    = ovf_m;
        e.udf    = udf_m;
        e.rd_ok  = r & ~m_empty;
        e.rbyte  = m_empty ? 8'h00 : model_q[0];
        exp_q.push_back(e);

        if (rs) begin
            model_q.delete();
            wr_acc = 0;
            rd_acc = 0;
            ovf_m  = 1'b0;
            udf_m  = 1'b0;
        end else begin
            if (r && !m_empty) begin
                void'(model_q.pop_front());
                rd_acc++;
            end
            if (w && !m_full) begin
                model_q.push_back(wdata[7:0]);
                model_q.push_back(wdata[15:8]);
                wr_acc++;
            end
            if (w && m_full)      ovf_m = 1'b1;
            else if (c)           ovf_m = 1'b0;
            if (r && m_empty)     udf_m = 1'b1;
            else if (c)           udf_m = 1'b0;
        end
    endtask

    initial begin
        int p_wr;
        int p_rd;
        checks  = 0;
        errors  = 0;
        wr_acc  = 0;
        rd_acc  = 0;
        ovf_m   = 1'b0;
        udf_m   = 1'b0;
        reset   = 1'b1;
        wr      = 1'b0;
        rd      = 1'b0;
        err_clr = 1'b0;
        wdata   = 16'h0000;

        // Hold reset for two unchecked cycles so the DUT leaves X.
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle after reset, fill with four words, drain eight bytes.
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (8) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Full boundary: 8 -> 7 (still full) -> wr&rd at 7 -> clear ovf.
        repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Drain past empty for underflow, then write and read together at 0.
        repeat (9) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);

        // Error set and clear in the same cycle, then reset during a write.
        repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with rotating write/read bias.
        for (int i = 0; i < 1500; i++) begin
            case ((i / 50) % 3)
                0:       begin p_wr = 70; p_rd = 30; end
                1:       begin p_wr = 30; p_rd = 70; end
                default: begin p_wr = 50; p_rd = 50; end
            endcase
            cycle(($urandom_range(199, 0) == 0),
                  ($urandom_range(99, 0) < p_wr),
                  ($urandom_range(99, 0) < p_rd),
                  ($urandom_range(15, 0) == 0));
        end

        @(posedge clk);
        #1;
        wr      = 1'b0;
        rd      = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
